// File: rtl/wave_capture.sv
// Writer side of the double-buffered waveform RAM: waits for a positive-going zero
// crossing, captures 256 scaled samples into the hidden half, then swaps halves when the display idles.
module wave_capture (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic [7:0]  write_sample,
    output logic        write_enable,
    output logic        read_index,
    output logic [1:0]  debug_state
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  count;
    logic [7:0]  count_nxt;
    logic        prev_neg;
    logic        read_index_nxt;
    logic [8:0]  write_address_nxt;
    logic [7:0]  write_sample_nxt;
    logic        write_enable_nxt;
    logic        crossing;
    logic [7:0]  scaled;

    // Handshake: new_sample_in is consumed only in a cycle where new_sample_ready is high;
    // there is no back-pressure, so every strobe is either written or deliberately dropped.
    assign crossing    = new_sample_ready && prev_neg && !new_sample_in[15];
    assign scaled      = {~new_sample_in[15], new_sample_in[14:8]};
    assign debug_state = state;

    always_comb begin
        state_nxt         = state;
        count_nxt         = count;
        read_index_nxt    = read_index;
        write_enable_nxt  = 1'b0;
        write_address_nxt = write_address;
        write_sample_nxt  = write_sample;
        case (state)
            ST_ARMED: begin
                if (crossing) begin
                    write_enable_nxt  = 1'b1;
                    write_address_nxt = {~read_index, 8'd0};
                    write_sample_nxt  = scaled;
                    count_nxt         = 8'd1;
                    state_nxt         = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    write_enable_nxt  = 1'b1;
                    write_address_nxt = {~read_index, count};
                    write_sample_nxt  = scaled;
                    count_nxt         = count + 8'd1;
                    if (count == 8'd255) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // The display only swaps halves while it is outside the active region.
                if (wave_display_idle) begin
                    read_index_nxt = ~read_index;
                    state_nxt      = ST_ARMED;
                end
            end
            default: begin
                state_nxt = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_ARMED;
            count         <= 8'd0;
            prev_neg      <= 1'b0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= 9'd0;
            write_sample  <= 8'd0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            read_index    <= read_index_nxt;
            write_enable  <= write_enable_nxt;
            write_address <= write_address_nxt;
            write_sample  <= write_sample_nxt;
            if (new_sample_ready) begin
                prev_neg <= new_sample_in[15];
            end
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: a monitor scoreboards every RAM write against an
// expected queue of {address, data}, while the main thread checks control behaviour.
module tb_wave_capture;

    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = 16'd0;
    logic        wave_display_idle = 1'b0;
    logic [8:0]  write_address;
    logic [7:0]  write_sample;
    logic        write_enable;
    logic        read_index;
    logic [1:0]  debug_state;

    logic [16:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_count = 0;
    int          run_len = 0;
    int          max_run = 0;
    int          wr_mark;

    wave_capture dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_sample      (write_sample),
        .write_enable      (write_enable),
        .read_index        (read_index),
        .debug_state       (debug_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] conv(input logic [15:0] s);
        return s[15:8] ^ 8'h80;
    endfunction

    task automatic put(input logic [15:0] s);
        @(negedge clk);
        new_sample_ready = 1'b1;
        new_sample_in    = s;
    endtask

    task automatic gap();
        @(negedge clk);
        new_sample_ready = 1'b0;
        new_sample_in    = 16'hDEAD;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Back-to-back strobes; only the first 256 can ever be written.
    task automatic burst(input int n, input logic [15:0] seed, input logic [8:0] base);
        logic [15:0] s;
        for (int i = 0; i < n; i++) begin
            s = seed + 16'(i * 16'h0123);
            if (i < 256) exp_q.push_back({base + 9'(i), conv(s)});
            put(s);
        end
        gap();
    endtask

    // Scoreboard monitor, sampling just after each active edge.
    always @(posedge clk) begin
        logic [16:0] e;
        #1;
        if (write_enable) begin
            wr_count++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {15'd0, write_address, write_sample}, 32'h1FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write", {15'd0, write_address, write_sample}, {15'd0, e});
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        logic [15:0] s;
        logic [7:0]  d;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_addr", 32'(write_address), 32'd0);
        check("rst_data", 32'(write_sample), 32'd0);
        check("rst_ri", 32'(read_index), 32'd0);
        check("rst_state", 32'(debug_state), 32'(ST_ARMED));
        @(negedge clk);
        reset = 1'b1;

        // A first non-negative sample cannot trigger
        put(16'h0100);
        gap();
        idle_cycles(3);
        check("first_no_trig", 32'(wr_count), 32'd0);

        // Trigger on 0xFF00 -> 0x0000 and check latency of the first write
        put(16'hFF00);
        gap();
        exp_q.push_back({9'h100, 8'h80});
        put(16'h0000);
        @(posedge clk);
        #1;
        check("lat_we", 32'(write_enable), 32'd1);
        check("lat_addr", 32'(write_address), 32'h100);
        check("lat_data", 32'(write_sample), 32'h80);
        gap();
        @(posedge clk);
        #1;
        check("lat_we_drop", 32'(write_enable), 32'd0);
        check("active_state", 32'(debug_state), 32'(ST_ACTIVE));
        for (int i = 1; i < 256; i++) begin
            if (i == 1) begin
                s = 16'h7FFF; d = 8'hFF;
            end else if (i == 2) begin
                s = 16'h8000; d = 8'h00;
            end else begin
                s = 16'(i * 16'h0101); d = conv(s);
            end
            exp_q.push_back({9'h100 + 9'(i), d});
            put(s);
            gap();
        end
        idle_cycles(3);
        check("cap1_count", 32'(wr_count), 32'd256);
        check("cap1_q_empty", 32'(exp_q.size()), 32'd0);
        check("cap1_wait", 32'(debug_state), 32'(ST_WAIT));

        // WAIT with display busy: strobes (even a crossing) are ignored, no swap
        put(16'hFF00);
        gap();
        put(16'h0100);
        gap();
        idle_cycles(50);
        check("wait_ri", 32'(read_index), 32'd0);
        check("wait_no_write", 32'(wr_count), 32'd256);
        check("wait_state", 32'(debug_state), 32'(ST_WAIT));
        @(negedge clk);
        wave_display_idle = 1'b1;
        @(posedge clk);
        #1;
        check("swap_ri", 32'(read_index), 32'd1);
        check("swap_state", 32'(debug_state), 32'(ST_ARMED));
        @(negedge clk);
        wave_display_idle = 1'b0;

        // Non-trigger pairs
        put(16'h0001); put(16'h7FFF);
        put(16'h0000); put(16'hFFFF);
        put(16'h8000); put(16'h8000);
        gap();
        idle_cycles(3);
        check("non_trig", 32'(wr_count), 32'd256);
        check("non_trig_state", 32'(debug_state), 32'(ST_ARMED));

        // Back-to-back: 300 strobes after a crossing into the lower half
        wr_mark = wr_count;
        max_run = 0;
        burst(300, 16'h1234, 9'h000);
        idle_cycles(3);
        check("b2b_count", 32'(wr_count - wr_mark), 32'd256);
        check("b2b_run", 32'(max_run), 32'd256);
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);
        check("b2b_wait", 32'(debug_state), 32'(ST_WAIT));
        check("b2b_ri", 32'(read_index), 32'd1);

        // Crossing sample together with idle in WAIT: swap, no write, prev_neg updated
        put(16'hF000);
        gap();
        wr_mark = wr_count;
        @(negedge clk);
        new_sample_ready  = 1'b1;
        new_sample_in     = 16'h0100;
        wave_display_idle = 1'b1;
        @(posedge clk);
        #1;
        check("sim_ri", 32'(read_index), 32'd0);
        check("sim_state", 32'(debug_state), 32'(ST_ARMED));
        check("sim_no_we", 32'(write_enable), 32'd0);
        @(negedge clk);
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        put(16'h0200);
        gap();
        idle_cycles(2);
        check("sim_prev_neg", 32'(wr_count), 32'(wr_mark));
        put(16'hFFFF);
        gap();
        exp_q.push_back({9'h100, 8'h83});
        put(16'h0300);
        burst(255, 16'h0400, 9'h101);
        idle_cycles(3);
        check("cap3_count", 32'(wr_count - wr_mark), 32'd256);
        check("cap3_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        wave_display_idle = 1'b1;
        @(negedge clk);
        wave_display_idle = 1'b0;
        check("cap3_swap", 32'(read_index), 32'd1);

        // Asynchronous reset in the middle of a running capture
        put(16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            s = 16'h0050 + 16'(i);
            exp_q.push_back({9'h000 + 9'(i), conv(s)});
            put(s);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_we", 32'(write_enable), 32'd0);
        check("arst_addr", 32'(write_address), 32'd0);
        check("arst_data", 32'(write_sample), 32'd0);
        check("arst_ri", 32'(read_index), 32'd0);
        check("arst_state", 32'(debug_state), 32'(ST_ARMED));
        exp_q.delete();
        new_sample_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wr_mark = wr_count;
        put(16'h0100);
        gap();
        idle_cycles(3);
        check("post_rst_no_trig", 32'(wr_count), 32'(wr_mark));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
